// File: rtl/msg_entry_pkg.sv
// rtl/msg_entry_pkg.sv - shared constants and types for the message entry front end
package msg_entry_pkg;

  localparam logic [3:0]  CH_BLANK      = 4'd5;
  localparam logic [3:0]  CH_LAST_VALID = 4'd5;
  localparam int          NUM_DIGITS    = 8;
  localparam logic [31:0] MSG_BLANK     = 32'h5555_5555;

  // Action chosen for the current cycle after key priority resolution
  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_ENTER = 2'd1,
    ACT_BACK  = 2'd2,
    ACT_CLEAR = 2'd3
  } action_e;

  // Codes 0..4 are message characters and 5 is blank; everything above is rejected
  function automatic logic char_ok(input logic [3:0] c);
    return (c <= CH_LAST_VALID);
  endfunction

endpackage

// File: rtl/msg_entry_key_pulse.sv
// rtl/msg_entry_key_pulse.sv - key synchronizer, press edge detect and lockout hold-off
module key_pulse #(
  parameter int LOCKOUT = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic key_n,
  output logic pulse
);

  localparam int CW = (LOCKOUT < 1) ? 1 : $clog2(LOCKOUT + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          edge_q;
  logic [CW-1:0] lock_q;
  logic [CW-1:0] lock_d;

  // A falling edge on the synchronized key is a press unless the hold-off is still running
  assign pulse = edge_q & ~sync2_q & (lock_q == '0);

  // Reload the hold-off on a press, otherwise count it down to zero
  always_comb begin
    lock_d = lock_q;
    if (pulse) begin
      lock_d = CW'(LOCKOUT);
    end else if (lock_q != '0) begin
      lock_d = lock_q - CW'(1);
    end
  end

  // Flops reset to the released level so a key held through reset yields one press afterwards
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      edge_q  <= 1'b1;
      lock_q  <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      lock_q  <= lock_d;
    end
  end

endmodule

// File: rtl/msg_entry.sv
// rtl/msg_entry.sv - calculator-style eight-digit message entry with backspace and clear
module msg_entry
  import msg_entry_pkg::*;
#(
  parameter int LOCKOUT = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  sw,
  input  logic        key_enter,
  input  logic        key_back,
  input  logic        key_clear,
  output logic [31:0] digits,
  output logic [3:0]  count,
  output logic        full,
  output logic        err
);

  logic        enter_p;
  logic        back_p;
  logic        clear_p;
  action_e     act;

  logic [31:0] digits_q, digits_d;
  logic [3:0]  count_q, count_d;
  logic        err_q, err_d;

  key_pulse #(.LOCKOUT(LOCKOUT)) u_enter (
    .clk   (clk),
    .clr   (clr),
    .key_n (key_enter),
    .pulse (enter_p)
  );

  key_pulse #(.LOCKOUT(LOCKOUT)) u_back (
    .clk   (clk),
    .clr   (clr),
    .key_n (key_back),
    .pulse (back_p)
  );

  key_pulse #(.LOCKOUT(LOCKOUT)) u_clear (
    .clk   (clk),
    .clr   (clr),
    .key_n (key_clear),
    .pulse (clear_p)
  );

  // Clear beats back beats enter; losing pulses are simply dropped
  always_comb begin
    act = ACT_NONE;
    if (clear_p) begin
      act = ACT_CLEAR;
    end else if (back_p) begin
      act = ACT_BACK;
    end else if (enter_p) begin
      act = ACT_ENTER;
    end
  end

  // Next message, fill count and reject flag for the chosen action
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    err_d    = 1'b0;
    case (act)
      ACT_CLEAR: begin
        digits_d = MSG_BLANK;
        count_d  = 4'd0;
      end
      ACT_BACK: begin
        if (count_q != 4'd0) begin
          digits_d = {CH_BLANK, digits_q[31:4]};
          count_d  = count_q - 4'd1;
        end
      end
      ACT_ENTER: begin
        if (char_ok(sw) && (count_q < 4'(NUM_DIGITS))) begin
          digits_d = {digits_q[27:0], sw};
          count_d  = count_q + 4'd1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Message register, fill count and one-cycle reject pulse
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      digits_q <= MSG_BLANK;
      count_q  <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign digits = digits_q;
  assign count  = count_q;
  assign err    = err_q;
  assign full   = (count_q == 4'(NUM_DIGITS));

endmodule

// File: tb/tb_msg_entry.sv
// tb/tb_msg_entry.sv - self-checking bench for msg_entry
module tb_msg_entry;

  localparam int LOCKOUT = 16;
  localparam logic [2:0] K_E = 3'b001;
  localparam logic [2:0] K_B = 3'b010;
  localparam logic [2:0] K_C = 3'b100;

  logic        clk;
  logic        clr;
  logic [3:0]  sw;
  logic        key_enter;
  logic        key_back;
  logic        key_clear;
  logic [31:0] digits;
  logic [3:0]  count;
  logic        full;
  logic        err;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  c;
    logic        e;
  } exp_t;

  typedef struct {
    logic [2:0]  keys;
    logic [3:0]  s;
    logic [31:0] d;
    logic [3:0]  c;
    logic        e;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[16];
  int          n_pass;
  int          n_total;
  logic [31:0] cur_d;
  logic [3:0]  cur_c;

  msg_entry #(.LOCKOUT(LOCKOUT)) dut (
    .clk       (clk),
    .clr       (clr),
    .sw        (sw),
    .key_enter (key_enter),
    .key_back  (key_back),
    .key_clear (key_clear),
    .digits    (digits),
    .count     (count),
    .full      (full),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string name, input logic [31:0] d, input logic [3:0] c, input logic e);
    check({name, " digits"}, digits, d);
    check({name, " count"}, {28'd0, count}, {28'd0, c});
    check({name, " full"}, {31'd0, full}, {31'd0, (c == 4'd8)});
    check({name, " err"}, {31'd0, err}, {31'd0, e});
  endtask

  task automatic release_keys();
    @(negedge clk);
    key_enter = 1'b1;
    key_back  = 1'b1;
    key_clear = 1'b1;
    repeat (LOCKOUT + 4) @(posedge clk);
  endtask

  // Drive a press, queue its expected result, and compare when the update edge arrives
  task automatic apply(input string name, input logic [2:0] keys, input logic [3:0] s, input exp_t ex);
    exp_t got;
    @(negedge clk);
    sw        = s;
    key_enter = ~keys[0];
    key_back  = ~keys[1];
    key_clear = ~keys[2];
    sb.push_back(ex);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check({name, " pre-update digits"}, digits, cur_d);
    check({name, " pre-update err"}, {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    got = sb.pop_front();
    check_state(name, got.d, got.c, got.e);
    @(posedge clk); #1;
    check({name, " err after"}, {31'd0, err}, 32'd0);
    cur_d = got.d;
    cur_c = got.c;
    release_keys();
  endtask

  initial begin
    exp_t ex;
    n_pass    = 0;
    n_total   = 0;
    clr       = 1'b0;
    sw        = 4'd0;
    key_enter = 1'b1;
    key_back  = 1'b1;
    key_clear = 1'b1;
    cur_d     = 32'h5555_5555;
    cur_c     = 4'd0;

    vecs[0]  = '{K_E, 4'd0,  32'h5555_5550, 4'd1, 1'b0};
    vecs[1]  = '{K_E, 4'd1,  32'h5555_5501, 4'd2, 1'b0};
    vecs[2]  = '{K_E, 4'd2,  32'h5555_5012, 4'd3, 1'b0};
    vecs[3]  = '{K_E, 4'd3,  32'h5555_0123, 4'd4, 1'b0};
    vecs[4]  = '{K_E, 4'd4,  32'h5550_1234, 4'd5, 1'b0};
    vecs[5]  = '{K_E, 4'd0,  32'h5501_2340, 4'd6, 1'b0};
    vecs[6]  = '{K_E, 4'd1,  32'h5012_3401, 4'd7, 1'b0};
    vecs[7]  = '{K_E, 4'd2,  32'h0123_4012, 4'd8, 1'b0};
    vecs[8]  = '{K_E, 4'd2,  32'h0123_4012, 4'd8, 1'b1};
    vecs[9]  = '{K_B, 4'd2,  32'h5012_3401, 4'd7, 1'b0};
    vecs[10] = '{K_C, 4'd2,  32'h5555_5555, 4'd0, 1'b0};
    vecs[11] = '{K_E, 4'd9,  32'h5555_5555, 4'd0, 1'b1};
    vecs[12] = '{K_B, 4'd9,  32'h5555_5555, 4'd0, 1'b0};
    vecs[13] = '{K_E, 4'd5,  32'h5555_5555, 4'd1, 1'b0};
    vecs[14] = '{K_E, 4'd15, 32'h5555_5555, 4'd1, 1'b1};
    vecs[15] = '{K_B, 4'd0,  32'h5555_5555, 4'd0, 1'b0};

    // Reset state, both during and after reset
    repeat (3) @(posedge clk);
    #1;
    check_state("reset held", 32'h5555_5555, 4'd0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset released", 32'h5555_5555, 4'd0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ex.d = vecs[i].d;
      ex.c = vecs[i].c;
      ex.e = vecs[i].e;
      apply($sformatf("vec%0d", i), vecs[i].keys, vecs[i].s, ex);
    end

    // Bouncing enter key: low 3, high 2, low 10 gives exactly one character
    @(negedge clk);
    sw        = 4'd0;
    key_enter = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bounce pre count", {28'd0, count}, 32'd0);
    @(posedge clk); #1;
    check("bounce update count", {28'd0, count}, 32'd1);
    check("bounce update digits", digits, 32'h5555_5550);
    @(negedge clk);
    key_enter = 1'b1;
    repeat (2) @(negedge clk);
    key_enter = 1'b0;
    repeat (10) @(negedge clk);
    key_enter = 1'b1;
    repeat (LOCKOUT + 6) @(posedge clk);
    #1;
    check("bounce final count", {28'd0, count}, 32'd1);
    check("bounce final digits", digits, 32'h5555_5550);
    cur_d = 32'h5555_5550;
    cur_c = 4'd1;

    // Back and enter together at count 3: back wins, enter discarded
    apply("clr0", K_C, 4'd0, '{32'h5555_5555, 4'd0, 1'b0});
    apply("fill1", K_E, 4'd1, '{32'h5555_5551, 4'd1, 1'b0});
    apply("fill2", K_E, 4'd2, '{32'h5555_5512, 4'd2, 1'b0});
    apply("fill3", K_E, 4'd3, '{32'h5555_5123, 4'd3, 1'b0});
    apply("back+enter", K_E | K_B, 4'd4, '{32'h5555_5512, 4'd2, 1'b0});
    apply("clear+back", K_C | K_B, 4'd4, '{32'h5555_5555, 4'd0, 1'b0});

    // Reset asserted mid-lockout with enter held low
    @(negedge clk);
    sw        = 4'd1;
    key_enter = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold enter count", {28'd0, count}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1;
    check_state("mid-lockout reset", 32'h5555_5555, 4'd0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("post-reset pre count", {28'd0, count}, 32'd0);
    @(posedge clk); #1;
    check_state("post-reset enter", 32'h5555_5551, 4'd1, 1'b0);
    repeat (LOCKOUT + 4) @(posedge clk);
    #1;
    check("held key single press", {28'd0, count}, 32'd1);
    release_keys();
    #1;
    check("release no press", {28'd0, count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/msg_entry.md
# msg_entry

Character-entry front end for the eight-digit seven-segment message display. It takes a 4-bit character code from switches and debounced push-key presses, and shifts accepted characters into an eight-digit message register, calculator style. The register feeds the character-to-segment encoders, one per HEX digit, so this block is the writer for the display path. It also provides backspace, clear, a fill count and a reject pulse.

## Interface
- `LOCKOUT`, default 16: clock cycles a key is ignored after an accepted press (debounce hold-off); minimum 1.
- `clk`  in  1  system clock.
- `clr`  in  1  asynchronous, active-low reset.
- `sw`  in  4  character code to enter.
- `key_enter`  in  1  push key, active-low, asynchronous to `clk`.
- `key_back`  in  1  push key, active-low; delete newest character.
- `key_clear`  in  1  push key, active-low; blank the whole message.
- `digits`  out  32  message; digit7 = [31:28] (leftmost, oldest), digit0 = [3:0] (newest).
- `count`  out  4  characters entered, 0..8.
- `full`  out  1  high when `count` == 8.
- `err`  out  1  one-cycle pulse when an enter is rejected.

## Operation
- Character codes:
  - 0..4 are message characters.
  - 5 is blank.
  - 6..15 are invalid.
- Reset (`clr` low, asynchronous):
  - `digits` = 32'h5555_5555 (all blank).
  - `count` = 0, `full` = 0, `err` = 0.
  - All synchronizer and edge flops = 1 (idle key state).
  - All lockout counters = 0.
- Each key passes through 2-flop synchronization, then falling-edge detection. Output is a one-cycle press pulse.
- After a pulse, that key's lockout counter loads `LOCKOUT`. Further falling edges of that key are ignored until the counter reaches 0. Lockouts are independent per key.
- Enter pulse:
  - If `sw` ≤ 5 and `count` < 8: `digits` <= {digits[27:0], sw}, `count` + 1. Blank (5) counts as a character.
  - If `sw` ≥ 6: no change, `err` pulses.
  - If `count` == 8: no change, `err` pulses.
- Back pulse:
  - If `count` > 0: `digits` <= {4'd5, digits[31:4]}, `count` − 1.
  - If `count` == 0: no change, no `err`.
- Clear pulse: `digits` = all blank, `count` = 0. No `err`.
- Simultaneous pulses in one cycle: clear > back > enter. Only the highest-priority action executes; lower pulses are discarded, not queued. They still start their own lockout.
- `full` is combinational from `count` == 8.
- `err` is registered and high for exactly one cycle per rejected enter.

## Timing
- Key input low before rising edge k: synchronizer stage 1 captures it at k, stage 2 at k+1, and the press pulse is valid during cycle k+1..k+2.
- `digits`, `count` and `err` update at edge k+2. A press is therefore visible 2 cycles after first sampling.
- Lockout counting starts at edge k+2. A second falling edge is accepted only if it is synchronized at or after edge k+2+`LOCKOUT`.
- Holding a key low produces exactly one pulse. Release followed by a re-press inside the lockout produces none.
- If `clr` is asserted mid-lockout, the counter is cleared. A key already low when `clr` deasserts produces a pulse 2 cycles later, because the flops reset to 1.
- `sw` is sampled at the same edge that consumes the enter pulse. `sw` is not synchronized and must be stable around key presses.

## Structure
- Shared package:
  - `CH_BLANK` = 4'd5, `CH_LAST_VALID` = 4'd5.
  - `NUM_DIGITS` = 8.
  - Reset value `MSG_BLANK` = 32'h5555_5555.
- Sub-module `key_pulse`, instantiated three times:
  - Parameter `LOCKOUT`.
  - Ports: `clk`, `clr`, `key_n`, `pulse`.
  - Contains the 2-flop synchronizer, edge detect and lockout counter.
- Top level holds the priority decode, the message shift register, `count` and `err`.

## Test plan
- Reset, then five enters with `sw` = 0,1,2,3,4 spaced > `LOCKOUT` → `digits` = 32'h5550_1234, `count` = 5, `err` never high.
- Fill to 8, then enter again with `sw` = 2 → `digits` unchanged, `full` = 1, one-cycle `err`, `count` stays 8.
- Enter with `sw` = 4'd9 → no change, `err` pulse. Back at `count` = 0 → no change, no `err`.
- `key_enter` bounce: low 3 cycles, high 2, low 10 (`LOCKOUT` = 16) → exactly one character entered; update at the 3rd edge after first low sample.
- `key_back` and `key_enter` fall on the same cycle at `count` = 3 → `count` = 2, newest digit removed, nothing entered. Clear plus back together → all blank, `count` = 0.
- Assert `clr` mid-lockout with `key_enter` held low, then release `clr` → reset values, then one enter 2 cycles after deassertion.
